// File: rtl/fcp6_master_arbiter_if.sv
// Bundles the requester-side and FCP6-master-side signals of the arbiter.
// The arbiter connects through the slave view; its environment uses master.
interface fcp6_master_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_header;
    logic [8*NREQ-1:0] req_wdata;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [7:0]        rsp_rdata;
    logic              rsp_err;
    logic [IDW-1:0]    grant_id;
    logic              arb_busy;

    logic              m_start;
    logic [7:0]        m_header;
    logic [7:0]        m_wdata;
    logic              m_busy;
    logic [7:0]        m_rdata;

    modport slave (
        input  req_valid, req_header, req_wdata, m_busy, m_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, grant_id, arb_busy,
               m_start, m_header, m_wdata
    );

    modport master (
        output req_valid, req_header, req_wdata, m_busy, m_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, grant_id, arb_busy,
               m_start, m_header, m_wdata
    );
endinterface

// File: rtl/fcp6_master_arbiter.sv
// Round-robin arbiter and sequencer sharing one FCP6 master among NREQ
// requesters: one single-byte transaction per grant, with start/busy timeouts.
module fcp6_master_arbiter #(
    parameter int NREQ     = 4,
    parameter int START_TO = 8,
    parameter int TXN_TO   = 255
) (
    input logic                  clk,
    input logic                  rst,
    fcp6_master_arbiter_if.slave bus
);

    localparam int IDW  = $clog2(NREQ);
    localparam int CW   = IDW + 1;
    localparam int TMAX = (START_TO > TXN_TO) ? START_TO : TXN_TO;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] START_LIM = TW'(START_TO);
    localparam logic [TW-1:0] TXN_LIM   = TW'(TXN_TO);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TMAX);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LAUNCH    = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_RESP      = 3'd4;

    logic [2:0]      state_q,      state_d;
    logic [IDW-1:0]  last_grant_q, last_grant_d;
    logic [TW-1:0]   timer_q,      timer_d;
    logic            err_q,        err_d;
    logic [7:0]      rdata_q,      rdata_d;

    logic [NREQ-1:0] req_ready_q,  req_ready_d;
    logic [NREQ-1:0] rsp_valid_q,  rsp_valid_d;
    logic [7:0]      rsp_rdata_q,  rsp_rdata_d;
    logic            rsp_err_q,    rsp_err_d;
    logic [IDW-1:0]  grant_id_q,   grant_id_d;
    logic            arb_busy_q,   arb_busy_d;
    logic            m_start_q,    m_start_d;
    logic [7:0]      m_header_q,   m_header_d;
    logic [7:0]      m_wdata_q,    m_wdata_d;

    logic [IDW-1:0]  rr_win;
    logic            rr_found;
    logic [CW-1:0]   rr_cand;
    logic [TW-1:0]   timer_inc;

    // Search starts just past the last owner so a granted requester drops to lowest priority.
    always_comb begin
        rr_win   = last_grant_q;
        rr_found = 1'b0;
        rr_cand  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            rr_cand = {1'b0, last_grant_q} + CW'(i);
            if (rr_cand >= CW'(NREQ)) begin
                rr_cand = rr_cand - CW'(NREQ);
            end
            if (!rr_found && bus.req_valid[rr_cand[IDW-1:0]]) begin
                rr_found = 1'b1;
                rr_win   = rr_cand[IDW-1:0];
            end
        end
    end

    assign timer_inc = (timer_q == TIMER_MAX) ? timer_q : timer_q + TW'(1);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        timer_d      = timer_q;
        err_d        = err_q;
        rdata_d      = rdata_q;
        req_ready_d  = '0;
        rsp_valid_d  = '0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        grant_id_d   = grant_id_q;
        m_start_d    = 1'b0;
        m_header_d   = m_header_q;
        m_wdata_d    = m_wdata_q;

        case (state_q)
            S_IDLE: begin
                // A still-busy master (e.g. after a transaction timeout) blocks any new acceptance.
                if ((|bus.req_valid) && !bus.m_busy) begin
                    req_ready_d = NREQ'(1) << rr_win;
                    grant_id_d  = rr_win;
                    m_header_d  = bus.req_header[{rr_win, 3'b000} +: 8];
                    m_wdata_d   = bus.req_wdata[{rr_win, 3'b000} +: 8];
                    err_d       = 1'b0;
                    rdata_d     = 8'h00;
                    state_d     = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                m_start_d = 1'b1;
                timer_d   = '0;
                state_d   = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (bus.m_busy) begin
                    timer_d = '0;
                    state_d = S_WAIT_DONE;
                end else if (timer_q == START_LIM) begin
                    err_d   = 1'b1;
                    rdata_d = 8'h00;
                    state_d = S_RESP;
                end else begin
                    timer_d = timer_inc;
                end
            end
            S_WAIT_DONE: begin
                if (!bus.m_busy) begin
                    err_d   = 1'b0;
                    rdata_d = m_header_q[0] ? 8'h00 : bus.m_rdata;
                    state_d = S_RESP;
                end else if (timer_q == TXN_LIM) begin
                    err_d   = 1'b1;
                    rdata_d = 8'h00;
                    state_d = S_RESP;
                end else begin
                    timer_d = timer_inc;
                end
            end
            S_RESP: begin
                rsp_valid_d  = NREQ'(1) << grant_id_q;
                rsp_rdata_d  = rdata_q;
                rsp_err_d    = err_q;
                last_grant_d = grant_id_q;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        arb_busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= IDW'(NREQ - 1);
            timer_q      <= '0;
            err_q        <= 1'b0;
            rdata_q      <= 8'h00;
            req_ready_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= 8'h00;
            rsp_err_q    <= 1'b0;
            grant_id_q   <= '0;
            arb_busy_q   <= 1'b0;
            m_start_q    <= 1'b0;
            m_header_q   <= 8'h00;
            m_wdata_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            timer_q      <= timer_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            grant_id_q   <= grant_id_d;
            arb_busy_q   <= arb_busy_d;
            m_start_q    <= m_start_d;
            m_header_q   <= m_header_d;
            m_wdata_q    <= m_wdata_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.arb_busy  = arb_busy_q;
    assign bus.m_start   = m_start_q;
    assign bus.m_header  = m_header_q;
    assign bus.m_wdata   = m_wdata_q;

endmodule

// File: tb/tb_fcp6_master_arbiter.sv
// Self-checking bench for fcp6_master_arbiter: a directed vector table of
// single transactions plus sequences for fairness, timeouts and reset.
module tb_fcp6_master_arbiter;

    localparam int NREQ     = 4;
    localparam int START_TO = 8;
    localparam int TXN_TO   = 255;

    typedef struct {
        int         req;
        logic [7:0] hdr;
        logic [7:0] wdata;
        logic [7:0] mrdata;
        int         hold;
        logic [3:0] exp_ready;
        logic [1:0] exp_grant;
        logic [3:0] exp_rsp;
        logic [7:0] exp_rdata;
        logic       exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_compared = 0;
    int   n_mismatched = 0;

    // Master model knobs: model_delay=0 means busy never rises.
    int         model_delay = 2;
    int         model_hold  = 10;
    logic [7:0] model_rdata = 8'h00;
    int         m_phase = 0;
    int         m_cnt   = 0;

    vec_t vecs [4];

    fcp6_master_arbiter_if #(.NREQ(NREQ)) bus ();

    fcp6_master_arbiter #(
        .NREQ(NREQ),
        .START_TO(START_TO),
        .TXN_TO(TXN_TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // FCP6 master model: raises busy model_delay cycles after start, holds it model_hold cycles.
    always @(negedge clk) begin
        if (rst) begin
            bus.m_busy  = 1'b0;
            bus.m_rdata = 8'h00;
            m_phase     = 0;
        end else if (m_phase == 0) begin
            if (bus.m_start && model_delay > 0) begin
                m_phase = 1;
                m_cnt   = model_delay;
            end
        end else if (m_phase == 1) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                bus.m_busy  = 1'b1;
                bus.m_rdata = 8'hEE;
                m_phase     = 2;
                m_cnt       = model_hold;
            end
        end else begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                bus.m_busy  = 1'b0;
                bus.m_rdata = model_rdata;
                m_phase     = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic checkResetValues(input string name);
        checkOutput({name, "_req_ready"}, 32'(bus.req_ready), 32'd0);
        checkOutput({name, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        checkOutput({name, "_rsp_rdata"}, 32'(bus.rsp_rdata), 32'd0);
        checkOutput({name, "_rsp_err"},   32'(bus.rsp_err),   32'd0);
        checkOutput({name, "_grant_id"},  32'(bus.grant_id),  32'd0);
        checkOutput({name, "_arb_busy"},  32'(bus.arb_busy),  32'd0);
        checkOutput({name, "_m_start"},   32'(bus.m_start),   32'd0);
        checkOutput({name, "_m_header"},  32'(bus.m_header),  32'd0);
        checkOutput({name, "_m_wdata"},   32'(bus.m_wdata),   32'd0);
    endtask

    task automatic setReq(input int idx, input logic [7:0] hdr, input logic [7:0] wdata);
        bus.req_header[8*idx +: 8] = hdr;
        bus.req_wdata[8*idx +: 8]  = wdata;
    endtask

    // Advances until rsp_valid shows, bounded by limit; reports extra m_start pulses seen.
    task automatic waitRsp(input string name, input int limit, output int at_cyc, output int starts);
        int seen;
        seen   = 0;
        starts = 0;
        at_cyc = -1;
        for (int k = 0; k < limit; k++) begin
            tick();
            if (bus.m_start) starts++;
            if (bus.rsp_valid != '0) begin
                seen   = 1;
                at_cyc = cyc;
                break;
            end
        end
        checkOutput({name, "_rsp_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic applyStimulus(input vec_t v, input string name);
        int at_cyc;
        int starts;
        bus.req_valid = 4'b0001 << v.req;
        setReq(v.req, v.hdr, v.wdata);
        model_delay = 2;
        model_hold  = v.hold;
        model_rdata = v.mrdata;
        tick();
        checkOutput({name, "_req_ready"}, 32'(bus.req_ready), 32'(v.exp_ready));
        checkOutput({name, "_grant_id"},  32'(bus.grant_id),  32'(v.exp_grant));
        checkOutput({name, "_m_header"},  32'(bus.m_header),  32'(v.hdr));
        checkOutput({name, "_m_wdata"},   32'(bus.m_wdata),   32'(v.wdata));
        checkOutput({name, "_arb_busy"},  32'(bus.arb_busy),  32'd1);
        bus.req_valid = '0;
        tick();
        checkOutput({name, "_m_start"}, 32'(bus.m_start), 32'd1);
        waitRsp(name, 60, at_cyc, starts);
        checkOutput({name, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(v.exp_rsp));
        checkOutput({name, "_rsp_rdata"}, 32'(bus.rsp_rdata), 32'(v.exp_rdata));
        checkOutput({name, "_rsp_err"},   32'(bus.rsp_err),   32'(v.exp_err));
        checkOutput({name, "_m_header_held"}, 32'(bus.m_header), 32'(v.hdr));
        checkOutput({name, "_extra_starts"}, 32'(starts), 32'd0);
        tick();
        checkOutput({name, "_rsp_pulse_end"}, 32'(bus.rsp_valid), 32'd0);
        checkOutput({name, "_arb_idle"},      32'(bus.arb_busy),  32'd0);
    endtask

    initial begin
        int at_cyc;
        int starts;
        int s_cyc;
        int grants;
        int rsps;
        int blocked;
        int order [4];

        vecs[0] = '{req: 0, hdr: 8'hA5, wdata: 8'h3C, mrdata: 8'h77, hold: 10,
                    exp_ready: 4'b0001, exp_grant: 2'd0, exp_rsp: 4'b0001, exp_rdata: 8'h00, exp_err: 1'b0};
        vecs[1] = '{req: 2, hdr: 8'h54, wdata: 8'h00, mrdata: 8'h99, hold: 10,
                    exp_ready: 4'b0100, exp_grant: 2'd2, exp_rsp: 4'b0100, exp_rdata: 8'h99, exp_err: 1'b0};
        vecs[2] = '{req: 1, hdr: 8'h12, wdata: 8'h81, mrdata: 8'h5A, hold: 4,
                    exp_ready: 4'b0010, exp_grant: 2'd1, exp_rsp: 4'b0010, exp_rdata: 8'h5A, exp_err: 1'b0};
        vecs[3] = '{req: 3, hdr: 8'h01, wdata: 8'hC3, mrdata: 8'h66, hold: 1,
                    exp_ready: 4'b1000, exp_grant: 2'd3, exp_rsp: 4'b1000, exp_rdata: 8'h00, exp_err: 1'b0};
        order = '{0, 1, 2, 3};

        bus.req_valid  = '0;
        bus.req_header = '0;
        bus.req_wdata  = '0;

        $display("[TB] reset values");
        tick();
        tick();
        checkResetValues("reset");
        rst = 1'b0;
        tick();

        $display("[TB] vector table");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        $display("[TB] fairness");
        rst = 1'b1;
        bus.req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) setReq(i, 8'h11 + 8'(2 * i), 8'h40 + 8'(i));
        model_delay = 2;
        model_hold  = 3;
        tick();
        rst    = 1'b0;
        grants = 0;
        rsps   = 0;
        starts = 0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (bus.m_start) starts++;
            if (bus.req_ready != '0) begin
                checkOutput($sformatf("fair_grant%0d", grants), 32'(bus.req_ready), 32'(4'b0001 << order[grants % 4]));
                grants++;
            end
            if (bus.rsp_valid != '0) begin
                checkOutput($sformatf("fair_rsp%0d", rsps), 32'(bus.rsp_valid), 32'(4'b0001 << order[rsps % 4]));
                rsps++;
                if (rsps == 6) begin
                    bus.req_valid = '0;
                    break;
                end
            end
        end
        checkOutput("fair_grants", 32'(grants), 32'd6);
        checkOutput("fair_rsps",   32'(rsps),   32'd6);
        checkOutput("fair_starts", 32'(starts), 32'd6);
        blocked = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (bus.req_ready != '0) blocked++;
        end
        checkOutput("fair_no_more_grants", 32'(blocked), 32'd0);

        $display("[TB] start timeout");
        model_delay   = 0;
        bus.req_valid = 4'b0010;
        setReq(1, 8'h20, 8'h00);
        tick();
        checkOutput("sto_req_ready", 32'(bus.req_ready), 32'(4'b0010));
        bus.req_valid = '0;
        tick();
        checkOutput("sto_m_start", 32'(bus.m_start), 32'd1);
        s_cyc = cyc;
        waitRsp("sto", 40, at_cyc, starts);
        checkOutput("sto_latency",   32'(at_cyc - s_cyc), 32'(START_TO + 2));
        checkOutput("sto_rsp_valid", 32'(bus.rsp_valid),  32'(4'b0010));
        checkOutput("sto_rsp_err",   32'(bus.rsp_err),    32'd1);
        checkOutput("sto_rsp_rdata", 32'(bus.rsp_rdata),  32'd0);
        tick();
        checkOutput("sto_arb_idle", 32'(bus.arb_busy), 32'd0);
        model_delay = 2;

        $display("[TB] stuck busy");
        model_hold  = 300;
        model_rdata = 8'h3A;
        bus.req_valid = 4'b0001;
        setReq(0, 8'h30, 8'h00);
        setReq(3, 8'h0B, 8'hD2);
        tick();
        checkOutput("stuck_req_ready", 32'(bus.req_ready), 32'(4'b0001));
        bus.req_valid = 4'b1000;
        tick();
        checkOutput("stuck_m_start", 32'(bus.m_start), 32'd1);
        s_cyc = cyc;
        waitRsp("stuck", 400, at_cyc, starts);
        // Busy appears 2 cycles after start, WAIT_DONE begins a cycle later, then TXN_TO counts plus RESP.
        checkOutput("stuck_latency",   32'(at_cyc - s_cyc), 32'(TXN_TO + 5));
        checkOutput("stuck_rsp_valid", 32'(bus.rsp_valid),  32'(4'b0001));
        checkOutput("stuck_rsp_err",   32'(bus.rsp_err),    32'd1);
        checkOutput("stuck_rsp_rdata", 32'(bus.rsp_rdata),  32'd0);
        model_hold = 3;
        blocked = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (!bus.m_busy) break;
            if (bus.req_ready != '0 || bus.m_start) blocked++;
        end
        checkOutput("stuck_busy_released", 32'(bus.m_busy), 32'd0);
        checkOutput("stuck_no_accept",     32'(blocked),    32'd0);
        for (int k = 0; k < 3 && bus.req_ready == '0; k++) tick();
        checkOutput("stuck_next_ready", 32'(bus.req_ready), 32'(4'b1000));
        bus.req_valid = '0;
        waitRsp("stuck_next", 40, at_cyc, starts);
        checkOutput("stuck_next_rsp", 32'(bus.rsp_valid), 32'(4'b1000));
        checkOutput("stuck_next_err", 32'(bus.rsp_err),   32'd0);
        tick();

        $display("[TB] reset mid-transaction");
        applyStimulus(vecs[2], "pre_reset");
        model_hold = 50;
        bus.req_valid = 4'b0100;
        setReq(2, 8'h40, 8'h00);
        tick();
        checkOutput("rmid_req_ready", 32'(bus.req_ready), 32'(4'b0100));
        bus.req_valid = '0;
        tick();
        checkOutput("rmid_m_start", 32'(bus.m_start), 32'd1);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        checkResetValues("rmid");
        rst = 1'b0;
        model_hold = 3;
        rsps = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus.rsp_valid != '0) rsps++;
        end
        checkOutput("rmid_no_rsp", 32'(rsps), 32'd0);
        bus.req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) setReq(i, 8'h21, 8'h5E);
        tick();
        checkOutput("rmid_next_grant", 32'(bus.req_ready), 32'(4'b0001));
        checkOutput("rmid_next_id",    32'(bus.grant_id),  32'd0);
        bus.req_valid = '0;
        waitRsp("rmid_next", 40, at_cyc, starts);
        checkOutput("rmid_next_rsp", 32'(bus.rsp_valid), 32'(4'b0001));
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
